// File: rtl/stream_serializer.sv
// Width-down serializer: accepts IN_W-bit words and emits them as RATIO beats of
// OUT_W bits with valid/ready handshakes on both sides and last-flag passthrough.
module stream_serializer #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [IN_W-1:0]  s_data_i,
  input  logic             s_last_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [OUT_W-1:0] m_data_o,
  output logic             m_last_o
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

  if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_params
    $error("stream_serializer: IN_W must be a multiple of OUT_W with RATIO >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             beat_cnt, cnt_d;
  logic [RATIO-1:0][OUT_W-1:0]  word_q;
  logic                         last_q;
  logic                         load;
  logic                         last_beat;
  logic                         in_xfer;
  logic                         out_xfer;
  logic [CNT_W-1:0]             slice_sel;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign m_valid_o = (state_q == SEND);

  // Ready opens in SEND only as the final beat leaves, so a new word can follow with no bubble.
  assign s_ready_o = !rst && ((state_q == IDLE) || (last_beat && m_ready_i));

  assign in_xfer   = s_valid_i && s_ready_o;
  assign out_xfer  = m_valid_o && m_ready_i;

  assign slice_sel = (MSB_FIRST != 0) ? (LAST_BEAT - beat_cnt) : beat_cnt;
  assign m_data_o  = m_valid_o ? word_q[slice_sel] : '0;
  assign m_last_o  = m_valid_o && last_beat && last_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = beat_cnt;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_xfer) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (last_beat) begin
            cnt_d = '0;
            if (in_xfer) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = beat_cnt + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q  <= IDLE;
      beat_cnt <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_cnt <= cnt_d;
      if (load) begin
        word_q <= s_data_i;
        last_q <= s_last_i;
      end
    end
  end

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: an LSB-first and an MSB-first instance
// share one stimulus; table vectors, directed corner sequences and a random scoreboard.
module tb_stream_serializer;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int RATIO = IN_W / OUT_W;
  localparam int DEPTH = 8192;

  // Backpressure sequence: beats expected per cycle and the m_ready pattern driven.
  localparam logic [7:0] BP_L [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
  localparam logic [7:0] BP_M [7] = '{8'h44, 8'h33, 8'h33, 8'h33, 8'h33, 8'h22, 8'h11};
  localparam bit         BP_R [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam bit         BP_S [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] s_data = '0;

  logic        s_ready [2];
  logic        m_valid [2];
  logic        m_last  [2];
  logic [7:0]  m_data  [2];

  int vectors = 0;
  int miscompares = 0;

  // Scoreboard: expected {last, beat} per instance, filled when a word is accepted.
  logic [8:0] exp_mem [2][DEPTH];
  int         wr [2];
  int         rd [2];
  bit         stalled [2];
  logic       prev_last [2];
  logic [7:0] prev_data [2];
  int         words = 0;

  typedef struct {
    logic [31:0]     data;
    logic            last;
    logic [0:3][7:0] exp_seq;
  } vec_t;

  vec_t tbl [5];

  always #5 clk = ~clk;

  stream_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready[0]),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .m_valid_o (m_valid[0]),
    .m_ready_i (m_ready),
    .m_data_o  (m_data[0]),
    .m_last_o  (m_last[0])
  );

  stream_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready[1]),
    .s_data_i  (s_data),
    .s_last_i  (s_last),
    .m_valid_o (m_valid[1]),
    .m_ready_i (m_ready),
    .m_data_o  (m_data[1]),
    .m_last_o  (m_last[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_both_idle(input string name);
    check({name, "_valid_lsb"}, m_valid[0], 1'b0);
    check({name, "_valid_msb"}, m_valid[1], 1'b0);
  endtask

  // Reference model: a word becomes RATIO beats taken from the word by shifting, in spec order.
  task automatic sb_push(input int d, input logic [31:0] w, input logic l);
    for (int i = 0; i < RATIO; i++) begin
      int slot;
      logic [31:0] sh;
      slot = (d == 0) ? i : (RATIO - 1 - i);
      sh = w >> (OUT_W * slot);
      if (wr[d] < DEPTH) begin
        exp_mem[d][wr[d]] = {(l && (i == RATIO - 1)), sh[7:0]};
      end
      wr[d]++;
    end
  endtask

  task automatic sb_cycle(input bit sv, input bit mr);
    next_cycle();
    s_valid = sv;
    s_data  = $urandom();
    s_last  = 1'($urandom_range(0, 1));
    m_ready = mr;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (stalled[d]) begin
        check($sformatf("hold_valid_%0d", d), m_valid[d], 1'b1);
        check($sformatf("hold_data_%0d", d), {m_last[d], m_data[d]}, {prev_last[d], prev_data[d]});
      end
      if (m_valid[d] && m_ready) begin
        if (rd[d] < wr[d] && rd[d] < DEPTH) begin
          check($sformatf("sb_beat_%0d_%0d", d, rd[d]), {m_last[d], m_data[d]}, exp_mem[d][rd[d]]);
        end else begin
          check($sformatf("sb_extra_beat_%0d", d), m_valid[d], 1'b0);
        end
        rd[d]++;
      end
      if (s_valid && s_ready[d]) begin
        sb_push(d, s_data, s_last);
        if (d == 0) words++;
      end
      stalled[d]   = m_valid[d] && !m_ready;
      prev_last[d] = m_last[d];
      prev_data[d] = m_data[d];
    end
  endtask

  initial begin
    tbl[0] = '{data: 32'hDDCCBBAA, last: 1'b1, exp_seq: {8'hAA, 8'hBB, 8'hCC, 8'hDD}};
    tbl[1] = '{data: 32'hA1B2C3D4, last: 1'b0, exp_seq: {8'hD4, 8'hC3, 8'hB2, 8'hA1}};
    tbl[2] = '{data: 32'h00000000, last: 1'b1, exp_seq: {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[3] = '{data: 32'hFFFF0000, last: 1'b0, exp_seq: {8'h00, 8'h00, 8'hFF, 8'hFF}};
    tbl[4] = '{data: 32'h12345678, last: 1'b1, exp_seq: {8'h78, 8'h56, 8'h34, 8'h12}};

    // Reset values while rst is held.
    next_cycle();
    next_cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready_%0d", d), s_ready[d], 1'b0);
      check($sformatf("rst_valid_%0d", d), m_valid[d], 1'b0);
      check($sformatf("rst_last_%0d", d), m_last[d], 1'b0);
      check($sformatf("rst_data_%0d", d), m_data[d], 8'h00);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    check("post_rst_ready_lsb", s_ready[0], 1'b1);
    check("post_rst_ready_msb", s_ready[1], 1'b1);

    // Table vectors: one word each, m_ready held high.
    for (int v = 0; v < 5; v++) begin
      next_cycle();
      s_valid = 1'b1;
      s_data  = tbl[v].data;
      s_last  = tbl[v].last;
      m_ready = 1'b1;
      #1;
      check($sformatf("tbl%0d_idle_ready", v), s_ready[0], 1'b1);
      check_both_idle($sformatf("tbl%0d_idle", v));
      for (int k = 0; k < RATIO; k++) begin
        next_cycle();
        s_valid = 1'b0;
        s_data  = $urandom();
        #1;
        check($sformatf("tbl%0d_b%0d_lsb", v, k), m_data[0], tbl[v].exp_seq[k]);
        check($sformatf("tbl%0d_b%0d_msb", v, k), m_data[1], tbl[v].exp_seq[RATIO-1-k]);
        check($sformatf("tbl%0d_b%0d_valid", v, k), m_valid[0] && m_valid[1], 1'b1);
        check($sformatf("tbl%0d_b%0d_last_lsb", v, k), m_last[0], tbl[v].last && (k == RATIO - 1));
        check($sformatf("tbl%0d_b%0d_last_msb", v, k), m_last[1], tbl[v].last && (k == RATIO - 1));
        check($sformatf("tbl%0d_b%0d_sready", v, k), s_ready[0], (k == RATIO - 1));
      end
      next_cycle();
      #1;
      check_both_idle($sformatf("tbl%0d_after", v));
    end

    // Backpressure: 0x22 held for three stalled cycles; input changes after capture are ignored.
    next_cycle();
    s_valid = 1'b1;
    s_data  = 32'h44332211;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check("bp_accept_ready", s_ready[0], 1'b1);
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      s_valid = 1'b0;
      s_data  = 32'hFFFFFFFF;
      m_ready = BP_R[i];
      #1;
      check($sformatf("bp_c%0d_lsb", i), m_data[0], BP_L[i]);
      check($sformatf("bp_c%0d_msb", i), m_data[1], BP_M[i]);
      check($sformatf("bp_c%0d_valid", i), m_valid[0], 1'b1);
      check($sformatf("bp_c%0d_last", i), m_last[0], 1'b0);
      check($sformatf("bp_c%0d_sready", i), s_ready[0], BP_S[i]);
    end
    next_cycle();
    #1;
    check_both_idle("bp_after");

    // Back-to-back words: eight beats with no idle cycle.
    next_cycle();
    s_valid = 1'b1;
    s_data  = 32'h03020100;
    s_last  = 1'b0;
    m_ready = 1'b1;
    #1;
    check("b2b_accept_ready", s_ready[0], 1'b1);
    for (int k = 0; k < 2 * RATIO; k++) begin
      next_cycle();
      if (k == 0) begin
        s_data = 32'h07060504;
        s_last = 1'b1;
      end
      if (k == RATIO) s_valid = 1'b0;
      #1;
      check($sformatf("b2b_b%0d_lsb", k), m_data[0], 8'(k));
      check($sformatf("b2b_b%0d_msb", k), m_data[1], (k < RATIO) ? 8'(RATIO - 1 - k) : 8'(3 * RATIO - 1 - k));
      check($sformatf("b2b_b%0d_valid", k), m_valid[0] && m_valid[1], 1'b1);
      check($sformatf("b2b_b%0d_last", k), m_last[0], (k == 2 * RATIO - 1));
      check($sformatf("b2b_b%0d_sready", k), s_ready[0], (k == RATIO - 1) || (k == 2 * RATIO - 1));
    end
    next_cycle();
    #1;
    check_both_idle("b2b_after");

    // Reset mid-word: asserted while 0xCC is presented, after AA and BB have left.
    next_cycle();
    s_valid = 1'b1;
    s_data  = 32'hDDCCBBAA;
    s_last  = 1'b1;
    m_ready = 1'b1;
    #1;
    next_cycle();
    s_valid = 1'b0;
    #1;
    check("rmw_aa", m_data[0], 8'hAA);
    next_cycle();
    #1;
    check("rmw_bb", m_data[0], 8'hBB);
    next_cycle();
    #1;
    check("rmw_cc", m_data[0], 8'hCC);
    rst = 1'b1;
    #1;
    check_both_idle("rmw_async");
    check("rmw_async_ready", s_ready[0], 1'b0);
    check("rmw_async_data", m_data[0], 8'h00);
    check("rmw_async_last", m_last[0], 1'b0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("rmw_release_ready", s_ready[0], 1'b1);
    check_both_idle("rmw_release");
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      #1;
      check_both_idle($sformatf("rmw_quiet%0d", i));
    end

    // Random traffic against the scoreboard, then drain.
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0;
      rd[d] = 0;
      stalled[d] = 1'b0;
    end
    for (int cyc = 0; cyc < 40000 && words < 1000; cyc++) begin
      sb_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
    end
    check("rnd_word_count", (words >= 1000), 1'b1);
    for (int i = 0; i < 3 * RATIO; i++) begin
      sb_cycle(1'b0, 1'b1);
    end
    check("rnd_drained_lsb", rd[0], wr[0]);
    check("rnd_drained_msb", rd[1], wr[1]);
    check_both_idle("rnd_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
